// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line fetcher: orientation codes, FSM
// state encoding and the stored sprite bitmaps (active low, bit c = column c).
package sprite_pkg;

  localparam logic [1:0] UP     = 2'd0;
  localparam logic [1:0] RIGHT  = 2'd1;
  localparam logic [1:0] DOWN   = 2'd2;
  localparam logic [1:0] LEFT   = 2'd3;
  localparam int         MIRROR = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    GATHER = 2'd2,
    HOLD   = 2'd3
  } fetch_state_e;

  localparam int TBL_SPRITES = 9;

  localparam logic [7:0] SPRITE_TBL_8 [TBL_SPRITES][8] = '{
    '{8'hC3, 8'h99, 8'h3C, 8'h66, 8'h7E, 8'h3C, 8'h99, 8'hC3},
    '{8'hEF, 8'hCF, 8'h87, 8'h03, 8'h87, 8'hCF, 8'hC7, 8'hEF},
    '{8'hFF, 8'hE7, 8'hB0, 8'hC3, 8'h81, 8'h18, 8'h7E, 8'hFF},
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F},
    '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE},
    '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA},
    '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA}
  };

  localparam logic [15:0] SPRITE_TBL_16 [TBL_SPRITES][16] = '{
    '{16'hF00F, 16'hE007, 16'hC3C3, 16'h8FF1, 16'h9E79, 16'h9E79, 16'h8FF1, 16'h8001,
      16'h8001, 16'h8FF1, 16'h9E79, 16'h9E79, 16'h8FF1, 16'hC3C3, 16'hE007, 16'hF00F},
    '{16'hFFFE, 16'hFFFD, 16'hFFFB, 16'hFFF7, 16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F,
      16'hFEFF, 16'hFDFF, 16'hFBFF, 16'hF7FF, 16'hEFFF, 16'hDFFF, 16'hBFFF, 16'h7FFF},
    '{16'hFFFF, 16'hFFFF, 16'hF00F, 16'hE007, 16'hC003, 16'h8001, 16'h8001, 16'h8001,
      16'h8001, 16'h8001, 16'h8001, 16'hC003, 16'hE007, 16'hF00F, 16'hFFFF, 16'hFFFF},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
    '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
      16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF},
    '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555,
      16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555},
    '{16'h7FFE, 16'hBFFD, 16'hDFFB, 16'hEFF7, 16'hF7EF, 16'hFBDF, 16'hFDBF, 16'hFE7F,
      16'hFE7F, 16'hFDBF, 16'hFBDF, 16'hF7EF, 16'hEFF7, 16'hDFFB, 16'hBFFD, 16'h7FFE},
    '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
    '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE,
      16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE}
  };

  // RIGHT and LEFT pull one column out of every row, so they need the multi-cycle walk.
  function automatic logic needs_gather(input logic [1:0] dir);
    return (dir == RIGHT) || (dir == LEFT);
  endfunction

endpackage

// File: rtl/sprite_bitmap_rom.sv
// Combinational sprite bitmap lookup: (sprite id, row) -> one stored row,
// all ones (blank) for unpopulated or out-of-table ids.
module sprite_bitmap_rom
  import sprite_pkg::*;
#(
  parameter int SPRITE_SIZE = 8,
  parameter int NUM_SPRITES = 9,
  parameter int ID_W        = 4,
  parameter int LINE_W      = $clog2(SPRITE_SIZE)
) (
  input  logic [ID_W-1:0]        sprite_id,
  input  logic [LINE_W-1:0]      row,
  output logic [SPRITE_SIZE-1:0] row_data
);

  logic id_ok_s;

  assign id_ok_s = (32'(sprite_id) < NUM_SPRITES) && (32'(sprite_id) < TBL_SPRITES);

  if (SPRITE_SIZE == 16) begin : g_n16
    // 16x16 table lookup
    always_comb begin
      row_data = {SPRITE_SIZE{1'b1}};
      if (id_ok_s) begin
        row_data = SPRITE_TBL_16[sprite_id][row];
      end else begin
        row_data = {SPRITE_SIZE{1'b1}};
      end
    end
  end else begin : g_n8
    // 8x8 table lookup
    always_comb begin
      row_data = {SPRITE_SIZE{1'b1}};
      if (id_ok_s) begin
        row_data = SPRITE_TBL_8[sprite_id][row];
      end else begin
        row_data = {SPRITE_SIZE{1'b1}};
      end
    end
  end

endmodule

// File: rtl/sprite_line_fetch.sv
// Fetches one oriented/mirrored line of a sprite: UP/DOWN read a single row,
// RIGHT/LEFT gather one column bit per row over SPRITE_SIZE cycles.
module sprite_line_fetch
  import sprite_pkg::*;
#(
  parameter int  SPRITE_SIZE = 8,
  parameter int  NUM_SPRITES = 9,
  parameter int  ID_W        = 4,
  localparam int LINE_W      = $clog2(SPRITE_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ID_W-1:0]        sprite_ID,
  input  logic [2:0]             orientation,
  input  logic [LINE_W-1:0]      line_index,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SPRITE_SIZE-1:0] out_data
);

  localparam logic [LINE_W-1:0] LAST = LINE_W'(SPRITE_SIZE - 1);

  fetch_state_e           state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [2:0]             orient_q, orient_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic [LINE_W-1:0]      cnt_q, cnt_d;
  logic [SPRITE_SIZE-1:0] acc_q, acc_d;
  logic [SPRITE_SIZE-1:0] data_q, data_d;
  logic                   valid_q, valid_d;

  logic [LINE_W-1:0]      rom_row_s, col_s, base_s, tgt_s;
  logic [SPRITE_SIZE-1:0] rom_data_s, direct_s;

  // ROM address: the requested (or vertically flipped) row in DIRECT, the walk counter otherwise
  always_comb begin
    rom_row_s = cnt_q;
    if (state_q == DIRECT) begin
      if (orient_q[1:0] == DOWN) begin
        rom_row_s = LAST - line_q;
      end else begin
        rom_row_s = line_q;
      end
    end else begin
      rom_row_s = cnt_q;
    end
  end

  sprite_bitmap_rom #(
    .SPRITE_SIZE (SPRITE_SIZE),
    .NUM_SPRITES (NUM_SPRITES),
    .ID_W        (ID_W),
    .LINE_W      (LINE_W)
  ) u_rom (
    .sprite_id (id_q),
    .row       (rom_row_s),
    .row_data  (rom_data_s)
  );

  // Row-based line with optional horizontal mirror
  always_comb begin
    direct_s = rom_data_s;
    for (int j = 0; j < SPRITE_SIZE; j++) begin
      if (orient_q[MIRROR]) begin
        direct_s[j] = rom_data_s[SPRITE_SIZE-1-j];
      end else begin
        direct_s[j] = rom_data_s[j];
      end
    end
  end

  // Column gather: source column is N-1-line; the destination bit folds in LEFT's reversal and the mirror
  always_comb begin
    col_s = LAST - line_q;
    if (orient_q[1:0] == RIGHT) begin
      base_s = cnt_q;
    end else begin
      base_s = LAST - cnt_q;
    end
    if (orient_q[MIRROR]) begin
      tgt_s = LAST - base_s;
    end else begin
      tgt_s = base_s;
    end
  end

  // Next-state logic; flush overrides acceptance and completion
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    orient_d = orient_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    valid_d  = valid_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = {LINE_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            id_d     = sprite_ID;
            orient_d = orientation;
            line_d   = line_index;
            cnt_d    = {LINE_W{1'b0}};
            acc_d    = {SPRITE_SIZE{1'b1}};
            if (needs_gather(orientation[1:0])) begin
              state_d = GATHER;
            end else begin
              state_d = DIRECT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DIRECT: begin
          data_d  = direct_s;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        GATHER: begin
          acc_d[tgt_s] = rom_data_s[col_s];
          if (cnt_q == LAST) begin
            data_d  = acc_d;
            valid_d = 1'b1;
            cnt_d   = {LINE_W{1'b0}};
            state_d = HOLD;
          end else begin
            cnt_d   = cnt_q + LINE_W'(1);
            state_d = GATHER;
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      id_q     <= {ID_W{1'b0}};
      orient_q <= 3'b000;
      line_q   <= {LINE_W{1'b0}};
      cnt_q    <= {LINE_W{1'b0}};
      acc_q    <= {SPRITE_SIZE{1'b1}};
      data_q   <= {SPRITE_SIZE{1'b1}};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      orient_q <= orient_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule
